// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - shared types and default constants for the tick generator
package tick_gen_pkg;

    // Channel operating mode as captured on a load strobe.
    typedef enum logic {
        PERIODIC = 1'b0,
        ONE_SHOT = 1'b1
    } tick_mode_e;

    // Default divisor/counter width and reset divisor (1 s at 25 MHz).
    localparam int TG_CNT_W       = 26;
    localparam int TG_DEFAULT_DIV = 25000000;

endpackage

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one programmable divider channel producing tick/square/active
//
// Ports:
//   clock       system clock, all state on posedge
//   reset       synchronous active-low reset
//   enable      run enable (level); low pauses the channel
//   load        one-cycle strobe capturing divisor_in and mode_in
//   divisor_in  divisor to capture (0 is stored as 1)
//   mode_in     0 = periodic, 1 = one-shot
//   tick        registered one-cycle pulse per period
//   square      registered output toggling on every tick
//   active      channel armed and able to produce a further tick
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int CNT_W       = TG_CNT_W,
    parameter int DEFAULT_DIV = TG_DEFAULT_DIV
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] divisor_in,
    input  logic             mode_in,
    output logic             tick,
    output logic             square,
    output logic             active
);

    // A zero divisor would make the terminal compare wrap, so it is treated as 1.
    localparam logic [CNT_W-1:0] RESET_DIV =
        (DEFAULT_DIV == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_count;
    tick_mode_e       r_mode;
    logic             r_armed;
    logic             r_tick;
    logic             r_square;

    logic [CNT_W-1:0] w_div_next;
    logic [CNT_W-1:0] w_count_next;
    tick_mode_e       w_mode_next;
    logic             w_armed_next;
    logic             w_tick_next;
    logic             w_square_next;
    logic [CNT_W-1:0] w_load_div;
    logic             w_terminal;

    assign w_load_div = (divisor_in == '0) ? CNT_W'(1) : divisor_in;

    // r_div is never 0, so div-1 cannot underflow and count never passes it.
    assign w_terminal = (r_count == (r_div - CNT_W'(1)));

    always_comb begin
        w_div_next    = r_div;
        w_count_next  = r_count;
        w_mode_next   = r_mode;
        w_armed_next  = r_armed;
        w_square_next = r_square;
        w_tick_next   = 1'b0;

        if (load) begin
            // Load wins over enable: restart the period from a clean state.
            w_div_next    = w_load_div;
            w_mode_next   = tick_mode_e'(mode_in);
            w_count_next  = '0;
            w_armed_next  = 1'b1;
            w_square_next = 1'b0;
        end else if (enable && r_armed) begin
            if (w_terminal) begin
                w_count_next  = '0;
                w_tick_next   = 1'b1;
                w_square_next = ~r_square;
                // One-shot disarms on the edge that emits its only tick.
                if (r_mode == ONE_SHOT) begin
                    w_armed_next = 1'b0;
                end
            end else begin
                w_count_next = r_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_div    <= RESET_DIV;
            r_count  <= '0;
            r_mode   <= PERIODIC;
            r_armed  <= 1'b1;
            r_tick   <= 1'b0;
            r_square <= 1'b0;
        end else begin
            r_div    <= w_div_next;
            r_count  <= w_count_next;
            r_mode   <= w_mode_next;
            r_armed  <= w_armed_next;
            r_tick   <= w_tick_next;
            r_square <= w_square_next;
        end
    end

    assign tick   = r_tick;
    assign square = r_square;
    assign active = r_armed;

endmodule

// File: rtl/tick_generator.sv
// rtl/tick_generator.sv - array of independent programmable tick divider channels
//
// Ports:
//   clock       system clock, all state on posedge
//   reset       synchronous active-low reset
//   enable      per-channel run enable
//   load        per-channel load strobe for divisor_in/mode_in
//   divisor_in  divisor shared by every channel strobed in a cycle
//   mode_in     0 = periodic, 1 = one-shot
//   tick        per-channel one-cycle tick pulse
//   square      per-channel square wave toggling on each tick
//   active      per-channel armed status
module tick_generator
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = TG_CNT_W,
    parameter int DEFAULT_DIV = TG_DEFAULT_DIV
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] load,
    input  logic [CNT_W-1:0]  divisor_in,
    input  logic              mode_in,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] square,
    output logic [NUM_CH-1:0] active
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .enable     (enable[g]),
            .load       (load[g]),
            .divisor_in (divisor_in),
            .mode_in    (mode_in),
            .tick       (tick[g]),
            .square     (square[g]),
            .active     (active[g])
        );
    end

endmodule

// File: tb/tb_tick_generator.sv
// tb/tb_tick_generator.sv - directed self-checking bench for tick_generator
module tb_tick_generator;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] load;
    logic [CNT_W-1:0]  divisor_in;
    logic              mode_in;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] square;
    logic [NUM_CH-1:0] active;

    int checks = 0;
    int errors = 0;

    tick_generator #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .divisor_in (divisor_in),
        .mode_in    (mode_in),
        .tick       (tick),
        .square     (square),
        .active     (active)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b0;
        enable     = '0;
        load       = '0;
        divisor_in = '0;
        mode_in    = 1'b0;

        // Reset defaults: divisor 3 on all channels.
        step();
        step();
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_square", 32'(square), 32'h0);
        check("rst_active", 32'(active), 32'hF);
        reset  = 1'b1;
        enable = 4'hF;
        step(); check("def_e1_tick", 32'(tick), 32'h0);
        step(); check("def_e2_tick", 32'(tick), 32'h0);
        step(); check("def_e3_tick", 32'(tick), 32'hF);
        check("def_e3_square", 32'(square), 32'hF);
        step(); check("def_e4_tick", 32'(tick), 32'h0);
        step(); check("def_e5_square", 32'(square), 32'hF);
        step(); check("def_e6_tick", 32'(tick), 32'hF);
        check("def_e6_square", 32'(square), 32'h0);
        check("def_active", 32'(active), 32'hF);

        // Periodic load on ch1, divisor 5.
        load = 4'b0010; divisor_in = 8'd5; mode_in = 1'b0;
        step();
        load = '0;
        check("ld1_tick", 32'(tick[1]), 32'h0);
        check("ld1_square", 32'(square[1]), 32'h0);
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("p1_tick_k%0d", k), 32'(tick[1]), (k % 5 == 0) ? 32'h1 : 32'h0);
            check($sformatf("p1_sq_k%0d", k), 32'(square[1]), 32'((k / 5) % 2));
        end

        // One-shot on ch2, divisor 4.
        load = 4'b0100; divisor_in = 8'd4; mode_in = 1'b1;
        step();
        load = '0;
        check("os_ld_active", 32'(active[2]), 32'h1);
        check("os_ld_square", 32'(square[2]), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("os_pre_tick_k%0d", k), 32'(tick[2]), 32'h0);
            check($sformatf("os_pre_act_k%0d", k), 32'(active[2]), 32'h1);
        end
        step();
        check("os_tick", 32'(tick[2]), 32'h1);
        check("os_active_fall", 32'(active[2]), 32'h0);
        check("os_square", 32'(square[2]), 32'h1);
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("os_post_tick_k%0d", k), 32'(tick[2]), 32'h0);
            check($sformatf("os_post_sq_k%0d", k), 32'(square[2]), 32'h1);
        end
        check("os_post_active", 32'(active[2]), 32'h0);
        load = 4'b0100; divisor_in = 8'd4; mode_in = 1'b1;
        step();
        load = '0;
        check("os_rearm_active", 32'(active[2]), 32'h1);
        check("os_rearm_square", 32'(square[2]), 32'h0);

        // Divisor 0 then 1 on ch0: tick every cycle, square toggles every cycle.
        for (int d = 0; d <= 1; d++) begin
            load = 4'b0001; divisor_in = 8'(d); mode_in = 1'b0;
            step();
            load = '0;
            check($sformatf("d%0d_ld_tick", d), 32'(tick[0]), 32'h0);
            for (int k = 1; k <= 4; k++) begin
                step();
                check($sformatf("d%0d_tick_k%0d", d, k), 32'(tick[0]), 32'h1);
                check($sformatf("d%0d_sq_k%0d", d, k), 32'(square[0]), 32'(k % 2));
            end
        end

        // Enable pause on ch3, divisor 6.
        load = 4'b1000; divisor_in = 8'd6; mode_in = 1'b0;
        step();
        load = '0;
        step(); check("pz_c1_tick", 32'(tick[3]), 32'h0);
        step(); check("pz_c2_tick", 32'(tick[3]), 32'h0);
        enable[3] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("pz_hold_tick_k%0d", k), 32'(tick[3]), 32'h0);
            check($sformatf("pz_hold_sq_k%0d", k), 32'(square[3]), 32'h0);
        end
        enable[3] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("pz_res_tick_k%0d", k), 32'(tick[3]), 32'h0);
        end
        step();
        check("pz_tick", 32'(tick[3]), 32'h1);
        check("pz_square", 32'(square[3]), 32'h1);

        // Load with enable high mid-period restarts the count.
        step();
        step();
        load = 4'b1000; divisor_in = 8'd6; mode_in = 1'b0;
        step();
        load = '0;
        check("lp_tick", 32'(tick[3]), 32'h0);
        check("lp_square", 32'(square[3]), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("lp_tick_k%0d", k), 32'(tick[3]), 32'h0);
        end
        step();
        check("lp_tick6", 32'(tick[3]), 32'h1);

        // Reset mid-period beats a simultaneous load.
        step();
        step();
        reset = 1'b0;
        load = 4'hF; divisor_in = 8'd7; mode_in = 1'b1;
        step();
        load  = '0;
        reset = 1'b1;
        check("mr_tick", 32'(tick), 32'h0);
        check("mr_square", 32'(square), 32'h0);
        check("mr_active", 32'(active), 32'hF);
        step(); check("mr_e1_tick", 32'(tick), 32'h0);
        step(); check("mr_e2_tick", 32'(tick), 32'h0);
        step(); check("mr_e3_tick", 32'(tick), 32'hF);
        step(); check("mr_e4_tick", 32'(tick), 32'h0);
        check("mr_e4_active", 32'(active), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_generator.md
TICK_GENERATOR -- requirements
Module: tick_generator

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 26, meaning the divisor and counter width in bits.
REQ-003 SHALL have parameter DEFAULT_DIV, default 25000000, meaning the divisor loaded into every channel at reset (must fit CNT_W).
REQ-004 SHALL have port clock  input  1  meaning the single system clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  meaning the synchronous, active-low reset (0 = reset).
REQ-006 SHALL have port enable  input  NUM_CH  meaning the per-channel run enable (level).
REQ-007 SHALL have port load  input  NUM_CH  meaning the per-channel one-cycle strobe that captures divisor_in and mode_in.
REQ-008 SHALL have port divisor_in  input  CNT_W  meaning the divisor shared by all channels strobed in a cycle.
REQ-009 SHALL have port mode_in  input  1  meaning 0 = periodic, 1 = one-shot.
REQ-010 SHALL have port tick  output  NUM_CH  meaning the registered one-cycle pulse per channel period.
REQ-011 SHALL have port square  output  NUM_CH  meaning the registered 50% duty output that toggles on each tick.
REQ-012 SHALL have port active  output  NUM_CH  meaning the channel is armed and will produce a further tick when enabled.

Function
REQ-013 SHALL give each channel its own divisor register div, mode bit, counter count, and armed bit; divisor_in == 0 SHALL be stored as 1.
REQ-014 SHALL, on an edge where load[i]=1: capture div/mode, clear count to 0, set armed, clear square[i], and drive tick[i]=0, regardless of enable[i].
REQ-015 SHALL, on an edge where load[i]=0, enable[i]=1, and armed=1: if count == div-1 then count <= 0, tick[i] <= 1, square[i] toggles; else count <= count+1, tick[i] <= 0.
REQ-016 SHALL, on an edge where enable[i]=0 or armed=0 (no load): hold count and square, and drive tick[i] <= 0.
REQ-017 SHALL produce the first tick D edges after the load edge with divisor D, and every D enabled edges thereafter in periodic mode; tick period = D cycles, square period = 2D cycles.
REQ-018 SHALL, with D=1, assert tick every enabled cycle and toggle square every cycle.
REQ-019 SHALL, in one-shot mode, clear armed on the edge that produces the tick; afterwards tick stays 0 and square and count hold until the next load.
REQ-020 SHALL keep armed permanently set in periodic mode; active[i] SHALL equal armed for channel i.
REQ-021 SHALL let multiple channels load in the same cycle, each capturing the same divisor_in and mode_in.
REQ-022 SHALL never let count exceed div-1, and SHALL perform no counter overflow or wrap other than the div-1 -> 0 transition.
REQ-023 SHALL pause a channel when enable drops mid-period, and resume it from the held count, so total enabled edges between ticks equal D.

Reset
REQ-024 SHALL, when reset=0 at a clock edge, set per channel: div=DEFAULT_DIV, mode=periodic, count=0, armed=1, tick=0, square=0, active=1.
REQ-025 SHALL give reset priority over load and enable; reset mid-period SHALL discard the partial count.

Structure
REQ-026 SHALL place the mode enum (PERIODIC, ONE_SHOT) and the default CNT_W/DEFAULT_DIV constants in package tick_gen_pkg.
REQ-027 SHALL implement one channel as sub-module tick_channel (parameter CNT_W) and instantiate it NUM_CH times by generate loop; the top SHALL contain no other state.

Verification
REQ-028 SHALL cover reset defaults: NUM_CH=4, CNT_W=8, DEFAULT_DIV=3, hold reset 2 cycles then release, enable=4'hF -> tick on every 3rd edge for all channels, square period 6, active=4'hF.
REQ-029 SHALL cover load and periodic mode: load ch1 with divisor 5, mode 0 -> tick[1] exactly 5 edges after load, then every 5 cycles, square[1] low after load and toggling each tick.
REQ-030 SHALL cover one-shot mode: load ch2 with divisor 4, mode 1 -> single tick at load+4, active[2] falls on the same edge, no further ticks over 20 cycles; a reload re-arms it.
REQ-031 SHALL cover divisor 0 and 1: load ch0 with 0 -> tick[0] high every enabled cycle; repeat with 1 -> identical behaviour.
REQ-032 SHALL cover enable pause: divisor 6, drop enable[3] for 3 cycles after 2 counts -> next tick arrives 4 enabled edges after resume, no tick during pause, square held.
REQ-033 SHALL cover load priority and reset mid-operation: assert load and enable together, and pull reset low mid-period -> load restarts count at 0 with tick=0; reset restores REQ-024 values on the next edge.
